// File: rtl/biquad_filter_engine_if.sv
// Sample stream interface for biquad_filter_engine.
//   sample_valid / sample_in  : producer -> engine input sample strobe and data
//   sample_ready              : engine can accept a sample this cycle
//   out_valid / sample_out    : engine -> consumer one-cycle result pulse, held data
// master = sample producer / result consumer, slave = the filter engine.
interface biquad_filter_engine_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           sample_ready;
    logic                           out_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;

    modport master (
        output sample_valid,
        output sample_in,
        input  sample_ready,
        input  out_valid,
        input  sample_out
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        output sample_ready,
        output out_valid,
        output sample_out
    );
endinterface

// File: rtl/biquad_filter_engine.sv
// biquad_filter_engine: direct-form-I biquad with an external coefficient unit.
// A loader FSM requests new coefficients (coeff_start/coeff_freq/coeff_ready),
// latches b0..a2 into a shadow bank, and the filter FSM copies it to the
// active bank while idle. Each sample takes 5 MAC cycles on one multiplier,
// DIV_STEPS restoring-divide cycles (acc / a0), then one output cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cutoff_in/_update     cutoff request, captured into coeff_freq
//   coeff_start/_freq     request to the coefficient unit
//   coeff_ready           coefficient unit idle/done
//   b0,b1,b2,a0,a1,a2     signed Q8.16 coefficients from the unit
//   smp                   sample stream interface (slave)
//   coeff_loaded, overrun sticky status flags
// Optional: define BIQUAD_HISTORY_CLEAR_EN to zero x1/x2/y1/y2 on every
// shadow-to-active coefficient copy; otherwise history persists.
//
// Loader FSM
//   state       | meaning
//   C_IDLE      | no request in flight; leave when a request is pending
//   C_REQ       | wait for coeff_ready, then pulse coeff_start
//   C_WAIT_LOW  | wait for the unit to drop coeff_ready (busy)
//   C_WAIT_HIGH | wait for coeff_ready, then latch shadow bank
// Filter FSM
//   state       | meaning
//   F_IDLE      | waiting for a sample; shadow copy happens here
//   F_MAC       | 5 multiply-accumulate steps into acc
//   F_DIV       | restoring divide |acc|/|a0|
//   F_OUT       | result pulse, history shift
module biquad_filter_engine #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int DIV_STEPS    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic        [SAMPLE_WIDTH-1:0] cutoff_in,
    input  logic                           cutoff_update,
    output logic                           coeff_start,
    output logic        [SAMPLE_WIDTH-1:0] coeff_freq,
    input  logic                           coeff_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] b0,
    input  logic signed [SAMPLE_WIDTH-1:0] b1,
    input  logic signed [SAMPLE_WIDTH-1:0] b2,
    input  logic signed [SAMPLE_WIDTH-1:0] a0,
    input  logic signed [SAMPLE_WIDTH-1:0] a1,
    input  logic signed [SAMPLE_WIDTH-1:0] a2,
    biquad_filter_engine_if.slave          smp,
    output logic                           coeff_loaded,
    output logic                           overrun
);
    localparam int SW    = SAMPLE_WIDTH;
    localparam int ACC_W = 2 * SW + 3;
    localparam int CW    = $clog2(DIV_STEPS) + 1;
    localparam int EW    = (DIV_STEPS > SW) ? DIV_STEPS + 1 : SW + 1;
    localparam logic signed [SW-1:0] MAX_S = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = {1'b1, {(SW-1){1'b0}}};
    localparam logic [EW-1:0] MAX_E = {{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic [EW-1:0] MIN_E = MAX_E + 1'b1;

    typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT_LOW, C_WAIT_HIGH} c_state_t;
    typedef enum logic [1:0] {F_IDLE, F_MAC, F_DIV, F_OUT} f_state_t;

    c_state_t c_state, c_next;
    f_state_t f_state, f_next;
    logic pending, shadow_valid, latch_shadow, clear_pending;
    logic signed [SW-1:0] shd [6];   // b0, b1, b2, a0, a1, a2
    logic signed [SW-1:0] act [6];
    logic [CW-1:0] cnt;
    logic signed [SW-1:0] x0, x1, x2, y1, y2;
    logic signed [ACC_W-1:0] acc, acc_next, acc_term;
    logic signed [SW-1:0] mul_a, mul_b;
    logic signed [2*SW-1:0] prod;
    logic sub;
    logic [ACC_W-1:0] acc_mag;
    logic [SW-1:0] a0_mag, d_mag, rem, rem_nx;
    logic [SW:0] rem_sh;
    logic rem_ge;
    logic [DIV_STEPS-1:0] dvd, quo, quo_nx;
    logic div_ovf, div_neg, div_zero;
    logic [EW-1:0] q_ext;
    logic signed [SW-1:0] result;
    logic sample_ready_i, accept, do_copy;

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) c_state <= C_IDLE;
        else       c_state <= c_next;
    end

    always_comb begin
        c_next        = c_state;
        coeff_start   = 1'b0;
        latch_shadow  = 1'b0;
        clear_pending = 1'b0;
        case (c_state)
            C_IDLE:      if (pending) c_next = C_REQ;
            C_REQ: begin
                if (coeff_ready && !reset) begin
                    coeff_start   = 1'b1;
                    clear_pending = 1'b1;
                    c_next        = C_WAIT_LOW;
                end
            end
            C_WAIT_LOW:  if (!coeff_ready) c_next = C_WAIT_HIGH;
            C_WAIT_HIGH: begin
                if (coeff_ready) begin
                    latch_shadow = 1'b1;
                    c_next       = C_IDLE;
                end
            end
            default:     c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coeff_freq   <= '0;
            pending      <= 1'b0;
            shadow_valid <= 1'b0;
            for (int i = 0; i < 6; i++) shd[i] <= '0;
        end else begin
            if (clear_pending) pending <= 1'b0;
            // a new update always wins, so a request landing while busy is kept
            if (cutoff_update) begin
                coeff_freq <= cutoff_in;
                pending    <= 1'b1;
            end
            if (do_copy) shadow_valid <= 1'b0;
            if (latch_shadow) begin
                shd[0] <= b0; shd[1] <= b1; shd[2] <= b2;
                shd[3] <= a0; shd[4] <= a1; shd[5] <= a2;
                shadow_valid <= 1'b1;
            end
        end
    end

    // ---------------- filter FSM ----------------
    assign do_copy          = (f_state == F_IDLE) && shadow_valid;
    assign sample_ready_i   = (f_state == F_IDLE) && coeff_loaded && !shadow_valid;
    assign smp.sample_ready = sample_ready_i;
    assign accept           = smp.sample_valid && sample_ready_i;

    always_ff @(posedge clk) begin
        if (reset) f_state <= F_IDLE;
        else       f_state <= f_next;
    end

    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE:  if (accept) f_next = F_MAC;
            F_MAC:   if (cnt == '0) f_next = F_DIV;
            F_DIV:   if (cnt == '0) f_next = F_OUT;
            F_OUT:   f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    // MAC operand select: cnt counts 4..0 through b0x0, b1x1, b2x2, a1y1, a2y2
    always_comb begin
        mul_a = act[5];
        mul_b = y2;
        sub   = 1'b1;
        case (cnt)
            CW'(4): begin mul_a = act[0]; mul_b = x0; sub = 1'b0; end
            CW'(3): begin mul_a = act[1]; mul_b = x1; sub = 1'b0; end
            CW'(2): begin mul_a = act[2]; mul_b = x2; sub = 1'b0; end
            CW'(1): begin mul_a = act[4]; mul_b = y1; sub = 1'b1; end
            default: ;
        endcase
        prod     = $signed({{SW{mul_a[SW-1]}}, mul_a}) * $signed({{SW{mul_b[SW-1]}}, mul_b});
        acc_term = {{(ACC_W-2*SW){prod[2*SW-1]}}, prod};
        acc_next = sub ? acc - acc_term : acc + acc_term;
        acc_mag  = acc_next[ACC_W-1] ? -acc_next : acc_next;
        a0_mag   = act[3][SW-1] ? -act[3] : act[3];
    end

    // One restoring step; the upper dividend bits were preloaded into rem,
    // which is valid because overflow (quotient >= 2^DIV_STEPS) was screened out.
    always_comb begin
        rem_sh = {rem, dvd[DIV_STEPS-1]};
        rem_ge = rem_sh >= {1'b0, d_mag};
        rem_nx = rem_ge ? SW'(rem_sh - {1'b0, d_mag}) : SW'(rem_sh);
        quo_nx = {quo[DIV_STEPS-2:0], rem_ge};
        q_ext  = EW'(quo_nx);
        if (div_zero)      result = '0;
        else if (div_ovf)  result = div_neg ? MIN_S : MAX_S;
        else if (!div_neg) result = (q_ext > MAX_E) ? MAX_S : SW'(q_ext);
        else               result = (q_ext > MIN_E) ? MIN_S : -SW'(q_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp.sample_out <= '0;
            smp.out_valid  <= 1'b0;
            coeff_loaded   <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < 6; i++) act[i] <= '0;
            x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
            acc <= '0; cnt <= '0; rem <= '0; dvd <= '0; quo <= '0; d_mag <= '0;
            div_ovf <= 1'b0; div_neg <= 1'b0; div_zero <= 1'b0;
        end else begin
            smp.out_valid <= 1'b0;
            if (do_copy) begin
                act          <= shd;
                coeff_loaded <= 1'b1;
`ifdef BIQUAD_HISTORY_CLEAR_EN
                x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
`endif
            end
            if (smp.sample_valid && !sample_ready_i) overrun <= 1'b1;
            case (f_state)
                F_IDLE: begin
                    if (accept) begin
                        x0  <= smp.sample_in;
                        acc <= '0;
                        cnt <= CW'(4);
                    end
                end
                F_MAC: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        cnt      <= CW'(DIV_STEPS - 1);
                        rem      <= SW'(acc_mag >> DIV_STEPS);
                        dvd      <= acc_mag[DIV_STEPS-1:0];
                        quo      <= '0;
                        d_mag    <= a0_mag;
                        div_zero <= (act[3] == '0);
                        div_ovf  <= (acc_mag >> DIV_STEPS) >= ACC_W'(a0_mag);
                        div_neg  <= acc_next[ACC_W-1] ^ act[3][SW-1];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                F_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    dvd <= dvd << 1;
                    if (cnt == '0) begin
                        smp.sample_out <= result;
                        smp.out_valid  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                F_OUT: begin
                    x2 <= x1;
                    x1 <= x0;
                    y2 <= y1;
                    y1 <= smp.sample_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_filter_engine.sv
// Testbench for biquad_filter_engine: directed samples with hand-computed
// results pushed into a scoreboard queue; a monitor pops on every out_valid
// and checks value and latency. A small coefficient-unit model answers
// coeff_start requests.
module tb_biquad_filter_engine;
    localparam int SW = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [SW-1:0] cutoff_in = '0;
    logic cutoff_update = 1'b0;
    logic coeff_start;
    logic [SW-1:0] coeff_freq;
    logic coeff_ready = 1'b1;
    logic signed [SW-1:0] b0 = '0, b1 = '0, b2 = '0, a0 = '0, a1 = '0, a2 = '0;
    logic coeff_loaded, overrun;

    biquad_filter_engine_if #(.SAMPLE_WIDTH(SW)) smp_if ();

    biquad_filter_engine #(.SAMPLE_WIDTH(SW), .DIV_STEPS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cutoff_in    (cutoff_in),
        .cutoff_update(cutoff_update),
        .coeff_start  (coeff_start),
        .coeff_freq   (coeff_freq),
        .coeff_ready  (coeff_ready),
        .b0           (b0),
        .b1           (b1),
        .b2           (b2),
        .a0           (a0),
        .a1           (a1),
        .a2           (a2),
        .smp          (smp_if.slave),
        .coeff_loaded (coeff_loaded),
        .overrun      (overrun)
    );

    typedef struct {
        logic [SW-1:0] val;
        int            t;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int starts = 0;
    int exp_starts = 0;
    logic [SW-1:0] exp1, exp2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // coefficient unit: drops ready the cycle after start, raises it 3 cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && coeff_start) begin
                starts++;
                @(posedge clk); #1 coeff_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 coeff_ready = 1'b1;
            end
        end
    end

    // result monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && smp_if.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", {31'd0, smp_if.out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sample_out", {8'd0, smp_if.sample_out}, {8'd0, e.val});
                    check("latency", cyc - e.t, 38);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic load(input logic [SW-1:0] f, input logic [SW-1:0] c0, c1, c2, c3, c4, c5);
        b0 = c0; b1 = c1; b2 = c2; a0 = c3; a1 = c4; a2 = c5;
        cutoff_in = f;
        cutoff_update = 1'b1;
        @(posedge clk); #1 cutoff_update = 1'b0;
        exp_starts++;
        repeat (16) @(posedge clk);
        #1;
        check("coeff_starts", starts, exp_starts);
        check("coeff_freq", {8'd0, coeff_freq}, {8'd0, f});
        check("coeff_loaded", {31'd0, coeff_loaded}, 32'd1);
    endtask

    task automatic send(input logic [SW-1:0] x, input logic [SW-1:0] ex, input bit push);
        for (int i = 0; i < 100 && !smp_if.sample_ready; i++) begin
            @(posedge clk); #1;
        end
        check("sample_ready_wait", {31'd0, smp_if.sample_ready}, 32'd1);
        smp_if.sample_valid = 1'b1;
        smp_if.sample_in = x;
        if (push) sb.push_back('{ex, cyc});
        @(posedge clk); #1 smp_if.sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);
    endtask

    initial begin
        smp_if.sample_valid = 1'b0;
        smp_if.sample_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_sample_out", {8'd0, smp_if.sample_out}, 32'd0);
        check("rst_out_valid", {31'd0, smp_if.out_valid}, 32'd0);
        check("rst_coeff_start", {31'd0, coeff_start}, 32'd0);
        check("rst_coeff_freq", {8'd0, coeff_freq}, 32'd0);
        check("rst_coeff_loaded", {31'd0, coeff_loaded}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_sample_ready", {31'd0, smp_if.sample_ready}, 32'd0);

        // identity filter
        load(24'h100000, 24'h010000, 24'h0, 24'h0, 24'h010000, 24'h0, 24'h0);
        send(24'h012345, 24'h012345, 1'b1);
        send(24'hFF0000, 24'hFF0000, 1'b1);
        drain();

        // feedback: y = x0 + x1 - 0.5*y1
`ifdef BIQUAD_HISTORY_CLEAR_EN
        exp1 = 24'h020000; exp2 = 24'h010000;
`else
        exp1 = 24'h018000; exp2 = 24'h014000;
`endif
        load(24'h080000, 24'h010000, 24'h010000, 24'h0, 24'h010000, 24'h008000, 24'h0);
        send(24'h020000, exp1, 1'b1);
        send(24'h000000, exp2, 1'b1);
        drain();

        // saturation
        load(24'h100000, 24'h7FFFFF, 24'h0, 24'h0, 24'h010000, 24'h0, 24'h0);
        send(24'h7FFFFF, 24'h7FFFFF, 1'b1);
        send(24'h800001, 24'h800000, 1'b1);
        drain();

        // negative divisor, truncation toward zero
        load(24'h100000, 24'h010000, 24'h0, 24'h0, 24'hFD0000, 24'h0, 24'h0);
        send(24'h010000, 24'hFFAAAB, 1'b1);
        send(24'hFE0000, 24'h00AAAA, 1'b1);
        drain();

        // quotient beyond divider range
        load(24'h100000, 24'h7FFFFF, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0);
        send(24'h7FFFFF, 24'h800000, 1'b1);
        drain();

        // updates while loader busy collapse into one further request
        b0 = 24'h010000; b1 = '0; b2 = '0; a0 = 24'h010000; a1 = '0; a2 = '0;
        cutoff_in = 24'h040000;
        cutoff_update = 1'b1;
        @(posedge clk); #1 cutoff_update = 1'b0;
        for (int i = 0; i < 20 && starts == exp_starts; i++) begin
            @(posedge clk); #1;
        end
        cutoff_in = 24'h080000; cutoff_update = 1'b1;
        @(posedge clk); #1 cutoff_in = 24'h0C0000;
        @(posedge clk); #1 cutoff_update = 1'b0;
        exp_starts += 2;
        repeat (30) @(posedge clk);
        #1;
        check("busy_update_starts", starts, exp_starts);
        check("busy_update_freq", {8'd0, coeff_freq}, 32'h000C0000);

        // dropped sample mid-computation
        check("overrun_before", {31'd0, overrun}, 32'd0);
        send(24'h054321, 24'h054321, 1'b1);
        repeat (9) @(posedge clk);
        #1 smp_if.sample_valid = 1'b1; smp_if.sample_in = 24'h111111;
        @(posedge clk); #1 smp_if.sample_valid = 1'b0;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        drain();

        // reset mid-computation
        send(24'h030000, 24'h0, 1'b0);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrst_sample_out", {8'd0, smp_if.sample_out}, 32'd0);
        check("midrst_coeff_loaded", {31'd0, coeff_loaded}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_coeff_freq", {8'd0, coeff_freq}, 32'd0);
        repeat (45) @(posedge clk);
        #1;
        check("midrst_no_pulse_out", {8'd0, smp_if.sample_out}, 32'd0);

        // history must be zero: y = x1 + x2 - 0.5*y1 - 0.25*y2
        load(24'h100000, 24'h0, 24'h010000, 24'h010000, 24'h010000, 24'h008000, 24'h004000);
        send(24'h030000, 24'h000000, 1'b1);
        send(24'h000000, 24'h030000, 1'b1);
        drain();

        // a0 = 0 yields 0
        load(24'h100000, 24'h010000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        send(24'h012345, 24'h000000, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/biquad_filter_engine.md
BIQUAD_FILTER_ENGINE -- requirements
Module: biquad_filter_engine

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, 24, width of samples and coefficients (signed Q8.16).
REQ-002 SHALL have parameter DIV_STEPS, 32, restoring-divider iterations (quotient magnitude bits).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cutoff_in  input  24  requested digital cutoff, captured on cutoff_update.
REQ-006 SHALL have port cutoff_update  input  1  request coefficient recomputation.
REQ-007 SHALL have port coeff_start  output  1  one-cycle start pulse to the coefficient unit.
REQ-008 SHALL have port coeff_freq  output  24  held cutoff driven to the coefficient unit.
REQ-009 SHALL have port coeff_ready  input  1  coefficient unit idle/done.
REQ-010 SHALL have ports b0,b1,b2,a0,a1,a2  input  24 each  signed Q8.16 coefficients.
REQ-011 SHALL have port sample_valid  input  1  input sample strobe.
REQ-012 SHALL have port sample_in  input  24  signed Q8.16 sample.
REQ-013 SHALL have port sample_ready  output  1  high only in F_IDLE with coeff_loaded=1.
REQ-014 SHALL have port out_valid  output  1  one-cycle result pulse.
REQ-015 SHALL have port sample_out  output  24  signed Q8.16 result, held between pulses.
REQ-016 SHALL have port coeff_loaded  output  1  sticky; at least one coefficient set active.
REQ-017 SHALL have port overrun  output  1  sticky; a sample was dropped.

Function
REQ-018 Loader FSM SHALL use C_IDLE, C_REQ, C_WAIT_LOW, C_WAIT_HIGH: C_IDLE plus pending request -> C_REQ; C_REQ pulses coeff_start in the first cycle coeff_ready=1 -> C_WAIT_LOW; coeff_ready=0 -> C_WAIT_HIGH; coeff_ready=1 -> latch b0..a2 into shadow bank, set shadow_valid -> C_IDLE.
REQ-019 cutoff_update SHALL capture cutoff_in into coeff_freq and set pending; updates arriving while the loader is busy overwrite coeff_freq/pending, so exactly one further request is issued, with the last value.
REQ-020 Shadow-to-active copy SHALL occur only in F_IDLE; it takes priority over same-cycle sample acceptance; coeff_loaded sets in the copy cycle.
REQ-021 Filter FSM SHALL use F_IDLE, F_MAC, F_DIV, F_OUT; sample accepted when sample_valid and sample_ready (cycle T).
REQ-022 F_MAC SHALL be 5 cycles (T+1..T+5) on one 24x24 multiplier: acc = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2, 51-bit signed Q16.32.
REQ-023 F_DIV SHALL be DIV_STEPS cycles computing |acc|/|a0| restoring, sign = sign(acc) XOR sign(a0), truncation toward zero.
REQ-024 Quotient SHALL saturate to 24'h7FFFFF / 24'h800000; a0=0 SHALL yield 0.
REQ-025 F_OUT (T+38 at default) SHALL drive sample_out, pulse out_valid, shift x2<=x1, x1<=x0, y2<=y1, y1<=result; then F_IDLE (sample_ready at T+39).
REQ-026 sample_valid while sample_ready=0 SHALL be dropped, set overrun, and not disturb the computation.

Reset
REQ-027 reset SHALL zero sample_out, out_valid, coeff_start, coeff_freq, coeff_loaded, overrun, both coefficient banks, shadow_valid, pending, x1, x2, y1, y2, acc, and force C_IDLE/F_IDLE.
REQ-028 reset mid-operation (any state) SHALL abort with no out_valid pulse and no history update.

Configuration
REQ-029 With BIQUAD_HISTORY_CLEAR_EN defined, x1, x2, y1, y2 SHALL zero in the shadow-to-active copy cycle; without it, history SHALL persist across coefficient swaps.

Verification
REQ-030 cutoff_update, cutoff_in=24'h100000; model drops coeff_ready 1 cycle after start, raises it 3 cycles later -> exactly one coeff_start, coeff_freq=24'h100000, coeff_loaded=1.
REQ-031 b0=a0=24'h010000, others 0; sample_in=24'h012345 at T -> out_valid at T+38, sample_out=24'h012345.
REQ-032 b0=24'h7FFFFF, a0=24'h010000, sample_in=24'h7FFFFF -> 24'h7FFFFF; sample_in=24'h800001 -> 24'h800000.
REQ-033 sample_valid at T+10 during computation -> overrun=1, T+38 result unchanged.
REQ-034 two cutoff_updates (24'h080000, then 24'h0C0000) while loader busy -> exactly one more coeff_start, coeff_freq=24'h0C0000.
REQ-035 reset at T+20 -> no out_valid, sample_out=0, history zero; a0=0 with any sample -> sample_out=0.
